// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the UART instruction loader.
// Holds the loader FSM state encoding, the load command byte and the
// end-of-program marker word.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAssemble = 2'd1,
    StWrite    = 2'd2,
    StRun      = 2'd3
  } loader_state_e;

  localparam logic [7:0]  LOAD_CMD   = 8'h4C;  // ASCII 'L'
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/loader_byte_assembler.sv
// Byte-to-word assembler for the instruction loader.
// Ports:
//   i_clk, i_reset  - clock and synchronous active-high reset
//   i_clear         - discard any partial word (shift register and count to 0)
//   i_accept        - i_byte is taken into the word this cycle
//   i_byte          - incoming byte, first byte of a word lands in bits [31:24]
//   o_word_next     - full word including the byte being accepted this cycle
//   o_word_ready    - strobe: the byte accepted this cycle completes a word
module loader_byte_assembler (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_ready
);

  // Only the three older bytes need storing; the fourth is used straight
  // from the input when the word completes.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (i_clear) begin
      shift_d = '0;
      count_d = '0;
    end else if (i_accept) begin
      shift_d = {shift_q[15:0], i_byte};
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign o_word_next  = {shift_q, i_byte};
  assign o_word_ready = i_accept && (count_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// UART-driven instruction loader.
// Waits for the 'L' command byte, then assembles following bytes MSB-first
// into 32-bit words and writes each one to instruction memory at consecutive
// word addresses. Loading ends on the all-ones end marker (which is still
// written) or when the address wraps; the pipeline is then released.
// Optional feature: define INSTRUCTION_LOADER_TIMEOUT_EN to abort a stalled
// word after TIMEOUT_CYCLES idle cycles in the assemble state.
// Ports:
//   i_clk, i_reset            - clock and synchronous active-high reset
//   i_rx_data, i_rx_valid     - received byte and its one-cycle strobe
//   o_write_instruction_flag  - instruction-memory write enable
//   o_instruction_to_write    - word to write (held between writes)
//   o_address_to_write_inst   - byte address of the write, zero-extended
//   o_halt                    - holds the fetch pipeline while not running
//   o_pipe_reset              - one-cycle pulse on entry to run
//   o_load_done               - high while the loaded program runs
//   o_overrun                 - one-cycle pulse when a byte was dropped
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_write_instruction_flag,
  output logic [31:0] o_instruction_to_write,
  output logic [31:0] o_address_to_write_inst,
  output logic        o_halt,
  output logic        o_pipe_reset,
  output logic        o_load_done,
  output logic        o_overrun
);

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 32) begin : g_addr_width_check
    $error("ADDR_WIDTH must be in the range 2..32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(4);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           winst_q, winst_d;
  logic                  overrun_q, overrun_d;
  logic                  pipe_reset_q, pipe_reset_d;

  logic        is_load_cmd;
  logic        asm_clear;
  logic        asm_accept;
  logic [31:0] asm_word_next;
  logic        asm_word_ready;
  logic        timeout_hit;

  assign is_load_cmd = i_rx_valid && (i_rx_data == LOAD_CMD);
  assign addr_inc    = addr_q + AddrStep;

  loader_byte_assembler u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (asm_clear),
    .i_accept     (asm_accept),
    .i_byte       (i_rx_data),
    .o_word_next  (asm_word_next),
    .o_word_ready (asm_word_ready)
  );

`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  logic [TmoW-1:0] tmo_q;

  // Counts consecutive idle cycles inside ASSEMBLE; any accepted byte or
  // leaving ASSEMBLE restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else if (state_q != StAssemble || i_rx_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StAssemble) && !i_rx_valid &&
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    winst_d      = winst_q;
    overrun_d    = 1'b0;
    asm_clear    = 1'b0;
    asm_accept   = 1'b0;

    unique case (state_q)
      StIdle, StRun: begin
        if (is_load_cmd) begin
          state_d   = StAssemble;
          addr_d    = '0;
          asm_clear = 1'b1;
        end
      end
      StAssemble: begin
        if (i_rx_valid) begin
          asm_accept = 1'b1;
          if (asm_word_ready) begin
            // Latch the write outputs now so they are valid in WRITE and
            // hold afterwards.
            state_d = StWrite;
            winst_d = asm_word_next;
            waddr_d = addr_q;
          end
        end else if (timeout_hit) begin
          state_d   = StIdle;
          asm_clear = 1'b1;
        end
      end
      StWrite: begin
        overrun_d = i_rx_valid;
        addr_d    = addr_inc;
        if (winst_q == END_MARKER || addr_inc == '0) begin
          state_d = StRun;
        end else begin
          state_d = StAssemble;
        end
      end
      default: state_d = StIdle;
    endcase

    pipe_reset_d = (state_d == StRun) && (state_q != StRun);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      waddr_q      <= '0;
      winst_q      <= '0;
      overrun_q    <= 1'b0;
      pipe_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      winst_q      <= winst_d;
      overrun_q    <= overrun_d;
      pipe_reset_q <= pipe_reset_d;
    end
  end

  assign o_write_instruction_flag = (state_q == StWrite);
  assign o_instruction_to_write   = winst_q;
  assign o_address_to_write_inst  = 32'(waddr_q);
  assign o_halt                   = (state_q != StRun);
  assign o_load_done              = (state_q == StRun);
  assign o_pipe_reset             = pipe_reset_q;
  assign o_overrun                = overrun_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  localparam int unsigned AW      = 8;
  localparam int unsigned MemSize = 1 << AW;
  localparam logic [7:0]  LCmd    = 8'h4C;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    bit          run_after;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_flag;
  logic [31:0] winst;
  logic [31:0] waddr;
  logic        halt;
  logic        pipe_reset;
  logic        load_done;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int pipe_cnt = 0;
  int ovr_cnt  = 0;

  wr_t        wq[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  bit         exp_running;
  int         exp_runs;

  instruction_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk                    (clk),
    .i_reset                  (rst),
    .i_rx_data                (rx_data),
    .i_rx_valid               (rx_valid),
    .o_write_instruction_flag (wr_flag),
    .o_instruction_to_write   (winst),
    .o_address_to_write_inst  (waddr),
    .o_halt                   (halt),
    .o_pipe_reset             (pipe_reset),
    .o_load_done              (load_done),
    .o_overrun                (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs mid-cycle; every write-enable cycle is one write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_flag) wq.push_back('{addr: waddr, data: winst});
      if (overrun) ovr_cnt++;
      if (pipe_reset) begin
        pipe_cnt++;
        total++;
        if (load_done !== 1'b1) begin
          bad++;
          $display("FAIL pipe_reset_outside_run: load_done=%b required 1", load_done);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Inputs change only at negedges; put() holds one byte valid for one cycle.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    put(b);
    idle(1);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    pipe_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (wq.size() > 0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  // Interprets a byte stream by the loader's rules (no overruns assumed):
  // 'L' starts a load at address 0, every 4 bytes form one word, the load
  // ends on the end marker or when the address wraps round memory.
  task automatic model_stream();
    bit          loading = 1'b0;
    bit          running = 1'b0;
    int          nb = 0;
    logic [31:0] w = '0;
    int unsigned a = 0;
    exp_q.delete();
    exp_runs = 0;
    foreach (stim_q[k]) begin
      if (!loading) begin
        if (stim_q[k] == LCmd) begin
          loading = 1'b1;
          running = 1'b0;
          nb = 0;
          a  = 0;
        end
      end else begin
        w = {w[23:0], stim_q[k]};
        nb++;
        if (nb == 4) begin
          exp_q.push_back('{addr: a, data: w});
          a  = (a + 4) % MemSize;
          nb = 0;
          if (w == 32'hFFFF_FFFF || a == 0) begin
            loading = 1'b0;
            running = 1'b1;
            exp_runs++;
          end
        end
      end
    end
    exp_running = running;
  endtask

  task automatic feed_stream();
    foreach (stim_q[k]) begin
      send_byte(stim_q[k]);
      idle($urandom_range(0, 2));
    end
    idle(3);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, wq.size(), exp_q.size());
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, wq[i].addr, exp_q[i].addr);
      check({tag, "_data"}, wq[i].data, exp_q[i].data);
    end
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, exp_running});
    check({tag, "_halt"}, {31'd0, halt}, {31'd0, !exp_running});
    check({tag, "_pipe_pulses"}, pipe_cnt, exp_runs);
  endtask

  initial begin
    vec_t        vecs[5];
    bit          ok;
    bit          need_l;
    wr_t         w;
    logic [31:0] rw;
    logic [7:0]  nb;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_halt", {31'd0, halt}, 32'd1);
    check("rst_wr_flag", {31'd0, wr_flag}, 32'd0);
    check("rst_inst", winst, 32'd0);
    check("rst_addr", waddr, 32'd0);
    check("rst_pipe_reset", {31'd0, pipe_reset}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Table: two loads, the second restarted by 'L' while running.
    vecs[0] = '{word: 32'h0000_0001, addr: 32'd0, run_after: 1'b0};
    vecs[1] = '{word: 32'hFFFF_FFFF, addr: 32'd4, run_after: 1'b1};
    vecs[2] = '{word: 32'hDEAD_BEEF, addr: 32'd0, run_after: 1'b0};
    vecs[3] = '{word: 32'h0000_004C, addr: 32'd4, run_after: 1'b0};
    vecs[4] = '{word: 32'hFFFF_FFFF, addr: 32'd8, run_after: 1'b1};

    send_byte(8'h12);
    idle(2);
    check("noise_ignored_writes", wq.size(), 0);
    check("noise_ignored_halt", {31'd0, halt}, 32'd1);

    need_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (need_l) begin
        send_byte(LCmd);
        check("load_start_halt", {31'd0, halt}, 32'd1);
        check("load_start_done", {31'd0, load_done}, 32'd0);
      end
      send_word(vecs[i].word);
      wait_write(ok);
      check("vec_write_seen", {31'd0, ok}, 32'd1);
      if (ok) begin
        w = wq.pop_front();
        check("vec_data", w.data, vecs[i].word);
        check("vec_addr", w.addr, vecs[i].addr);
      end
      idle(1);
      check("vec_load_done", {31'd0, load_done}, {31'd0, vecs[i].run_after});
      check("vec_halt", {31'd0, halt}, {31'd0, !vecs[i].run_after});
      check("vec_single_write", wq.size(), 0);
      need_l = vecs[i].run_after;
    end
    check("vec_pipe_pulses", pipe_cnt, 2);

    // Reset two bytes into a word, from a non-reset output state.
    send_byte(LCmd);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_halt", {31'd0, halt}, 32'd1);
    check("midrst_done", {31'd0, load_done}, 32'd0);
    check("midrst_inst", winst, 32'd0);
    check("midrst_addr", waddr, 32'd0);
    wq.delete();
    pipe_cnt = 0;
    stim_q = '{LCmd, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_stream();
    feed_stream();
    compare_writes("midrst_reload");

    // Byte arriving in the WRITE cycle is dropped and flagged.
    do_reset();
    send_byte(LCmd);
    put(8'h11);
    put(8'h22);
    put(8'h33);
    put(8'h44);
    put(8'h99);
    check("overrun_pulse", {31'd0, overrun}, 32'd1);
    idle(1);
    check("overrun_one_cycle", {31'd0, overrun}, 32'd0);
    send_word(32'h5566_7788);
    send_word(32'hFFFF_FFFF);
    idle(2);
    stim_q = '{LCmd, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_stream();
    compare_writes("overrun");
    check("overrun_count", ovr_cnt, 1);

    // Fill memory without an end marker: wraps after address 252.
    do_reset();
    stim_q.delete();
    stim_q.push_back(LCmd);
    for (int i = 0; i < 64; i++) begin
      rw = 32'h0101_0100 * i + 32'd7;
      for (int k = 3; k >= 0; k--) stim_q.push_back(rw[8*k +: 8]);
    end
    model_stream();
    feed_stream();
    compare_writes("wrap");
    if (wq.size() > 0) check("wrap_last_addr", wq[wq.size()-1].addr, 32'd252);
    else check("wrap_last_addr_missing", wq.size(), 64);

    // Stall mid-word for longer than the timeout.
    do_reset();
    send_byte(LCmd);
    send_byte(8'hAA);
    idle(18);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(3);
`ifdef INSTRUCTION_LOADER_TIMEOUT_EN
    check("timeout_no_write", wq.size(), 0);
    check("timeout_halt", {31'd0, halt}, 32'd1);
    check("timeout_done", {31'd0, load_done}, 32'd0);
`else
    check("notimeout_write", wq.size(), 1);
    if (wq.size() > 0) begin
      check("notimeout_data", wq[0].data, 32'hAA11_2233);
      check("notimeout_addr", wq[0].addr, 32'd0);
    end
`endif

    // Random streams with noise, random words and optional reload.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      stim_q.delete();
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == LCmd) nb = 8'h00;
        stim_q.push_back(nb);
      end
      for (int ld = 0; ld < 1 + int'($urandom_range(0, 1)); ld++) begin
        stim_q.push_back(LCmd);
        repeat ($urandom_range(1, 6)) begin
          rw = $urandom;
          if (rw == 32'hFFFF_FFFF) rw = 32'h0;
          for (int k = 3; k >= 0; k--) stim_q.push_back(rw[8*k +: 8]);
        end
        if ($urandom_range(0, 3) != 0) begin
          for (int k = 0; k < 4; k++) stim_q.push_back(8'hFF);
        end
        repeat ($urandom_range(0, 2)) begin
          nb = 8'($urandom_range(0, 255));
          if (nb == LCmd) nb = 8'h01;
          stim_q.push_back(nb);
        end
      end
      model_stream();
      feed_stream();
      compare_writes("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter: ADDR_WIDTH, 8, byte-address width of instruction memory (2^ADDR_WIDTH bytes, word-aligned).
REQ-002 Parameter: TIMEOUT_CYCLES, 1000000, idle cycles between bytes before abort (used only with the REQ-024 feature).
REQ-003 Port: i_clk, input, 1, single clock, all logic on rising edge.
REQ-004 Port: i_reset, input, 1, synchronous active-high reset.
REQ-005 Port: i_rx_data, input, 8, byte from UART receiver.
REQ-006 Port: i_rx_valid, input, 1, one-cycle strobe qualifying i_rx_data.
REQ-007 Port: o_write_instruction_flag, output, 1, instruction-memory write enable.
REQ-008 Port: o_instruction_to_write, output, 32, assembled instruction word.
REQ-009 Port: o_address_to_write_inst, output, 32, byte address for write, zero-extended from ADDR_WIDTH.
REQ-010 Port: o_halt, output, 1, holds fetch pipeline while not running.
REQ-011 Port: o_pipe_reset, output, 1, one-cycle pulse restarting PC/pipeline after load.
REQ-012 Port: o_load_done, output, 1, high while program loaded and running.
REQ-013 Port: o_overrun, output, 1, one-cycle pulse when a byte is dropped.

Function
REQ-014 The FSM SHALL have states IDLE, ASSEMBLE, WRITE, RUN.
- IDLE: wait for i_rx_valid with i_rx_data==8'h4C ('L'); other bytes ignored; on 'L' -> ASSEMBLE, address:=0, byte count:=0.
REQ-015 ASSEMBLE SHALL shift bytes MSB-first (first byte -> bits [31:24]); on 4th accepted byte -> WRITE next cycle.
REQ-016 WRITE SHALL last exactly one cycle: o_write_instruction_flag=1, o_instruction_to_write=assembled word, o_address_to_write_inst=current address.
REQ-017 After WRITE, address SHALL increment by 4; if the word was 32'hFFFFFFFF (end marker, still written) or address wraps to 0 -> RUN, else -> ASSEMBLE.
REQ-018 i_rx_valid during WRITE SHALL drop the byte and pulse o_overrun the following cycle; assembly state unaffected.
REQ-019 Entry to RUN SHALL pulse o_pipe_reset for exactly the first RUN cycle; o_load_done=1 throughout RUN.
REQ-020 o_halt SHALL be 1 in IDLE, ASSEMBLE, WRITE and 0 in RUN.
REQ-021 In RUN, byte 8'h4C SHALL restart loading (-> ASSEMBLE, address 0, o_halt=1 next cycle, o_load_done=0); other bytes ignored.
REQ-022 o_write_instruction_flag SHALL be 0 in all states except WRITE; write outputs hold last values otherwise.

Reset
REQ-023 i_reset SHALL, at any point including mid-load, force IDLE with o_halt=1 and all other outputs 0, address, byte count and shift register 0.

Configuration
REQ-024 With macro INSTRUCTION_LOADER_TIMEOUT_EN defined, a counter SHALL clear on every accepted byte and, on reaching TIMEOUT_CYCLES in ASSEMBLE, return to IDLE, discarding partial word (o_halt stays 1); without it, no counter exists and ASSEMBLE waits indefinitely.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, LOAD_CMD=8'h4C and END_MARKER=32'hFFFFFFFF.
REQ-026 One sub-module, loader_byte_assembler (shift register, byte counter, word-ready strobe), SHALL be instantiated; FSM and address counter stay in top.

Verification
REQ-027 Reset, then send 'L',00,00,00,01,FF,FF,FF,FF -> writes 32'h00000001@0 and 32'hFFFFFFFF@4, one-cycle pulses each; RUN, o_pipe_reset single pulse, o_halt=0.
REQ-028 Bytes 8'h12 then 'L' in IDLE -> 8'h12 ignored, load starts only after 'L'.
REQ-029 Load 64 words with no end marker (ADDR_WIDTH=8) -> last write at address 252, then RUN.
REQ-030 Assert i_rx_valid in the WRITE cycle -> o_overrun pulses, byte lost, next word assembled from following bytes.
REQ-031 Assert i_reset after 2 bytes of a word -> IDLE, o_halt=1; new 'L' load starts at address 0.
REQ-032 With INSTRUCTION_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: 'L',AA then 16 idle cycles -> IDLE, no write issued.
